// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the 640x480@60 VGA path on CLK_50.
// A divider makes the pixel-rate enable; horizontal/vertical counters are
// decoded into sync, display-area and line/frame start strobes. All outputs
// are registered and decoded from the next position, so they never skew
// against CounterX/CounterY.
// Optional build macro VGA_FRAME_COUNT_EN adds the 8-bit frame_count output.
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic       CLK_50,
  input  logic       RST,
  output logic       pix_en,
  output logic [9:0] CounterX,
  output logic [9:0] CounterY,
  output logic       InDisplayArea,
  output logic       h_sync,
  output logic       v_sync,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit constants so a full 1024-entry raster still compares correctly.
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

  // Counters are 10 bits wide and the divider 4 bits wide.
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_cfg
    $error("vga_timing_gen: raster totals must be <= 1024 and CLK_DIV in 1..16");
  end

  // IDLE holds the raster at (0,0) until the first pixel enable; RUN scans.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  div_cnt, div_nxt;
  logic        tick;
  logic [9:0]  x_nxt, y_nxt;

  function automatic logic in_display(input logic [9:0] x, input logic [9:0] y);
    return ({1'b0, x} < H_ACT) && ({1'b0, y} < V_ACT);
  endfunction

  function automatic logic hsync_level(input logic [9:0] x);
    return (({1'b0, x} >= HS_BEG) && ({1'b0, x} < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
  endfunction

  function automatic logic vsync_level(input logic [9:0] y);
    return (({1'b0, y} >= VS_BEG) && ({1'b0, y} < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
  endfunction

  // Divider look-ahead: tick marks the edge that loads div_cnt == CLK_DIV-1,
  // so the registered pix_en is high exactly while div_cnt == CLK_DIV-1.
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    tick    = (div_nxt == DIV_LAST);
  end

  // Next state and next raster position.
  always_comb begin
    state_nxt = state;
    x_nxt     = CounterX;
    y_nxt     = CounterY;
    case (state)
      IDLE: begin
        if (tick) state_nxt = RUN;
      end
      RUN: begin
        if (tick) begin
          if ({1'b0, CounterX} < H_LAST) begin
            x_nxt = CounterX + 10'd1;
          end else begin
            x_nxt = 10'd0;
            y_nxt = ({1'b0, CounterY} == V_LAST) ? 10'd0 : CounterY + 10'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_50) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Divider, position and output decode registers; strobes last one cycle.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      div_cnt       <= 4'd0;
      pix_en        <= 1'b0;
      CounterX      <= 10'd0;
      CounterY      <= 10'd0;
      InDisplayArea <= 1'b0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      h_sync        <= ~H_SYNC_POL;
      v_sync        <= ~V_SYNC_POL;
`ifdef VGA_FRAME_COUNT_EN
      frame_count   <= 8'd0;
`endif
    end else begin
      div_cnt     <= div_nxt;
      pix_en      <= tick;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        CounterX      <= x_nxt;
        CounterY      <= y_nxt;
        InDisplayArea <= in_display(x_nxt, y_nxt);
        h_sync        <= hsync_level(x_nxt);
        v_sync        <= vsync_level(y_nxt);
        line_start    <= (x_nxt == 10'd0);
        frame_start   <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
`ifdef VGA_FRAME_COUNT_EN
        // The very first frame_start after reset comes from IDLE and is not counted.
        if (state == RUN && x_nxt == 10'd0 && y_nxt == 10'd0)
          frame_count <= frame_count + 8'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: default 640x480 instance plus two small
// rasters (16x8 pixels) for frame-level timing, CLK_DIV = 1 and inverted
// sync polarity.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

  logic       a_pen, a_disp, a_hs, a_vs, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_pen, b_disp, b_hs, b_vs, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_pen, c_disp, c_hs, c_vs, c_ls, c_fs;
  logic [9:0] c_x, c_y;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] a_fc, b_fc, c_fc;
`endif

  int checks = 0;
  int failures = 0;

  vga_timing_gen u_a (
    .CLK_50(clk), .RST(rst_a), .pix_en(a_pen), .CounterX(a_x), .CounterY(a_y),
    .InDisplayArea(a_disp), .h_sync(a_hs), .v_sync(a_vs),
    .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(a_fc)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .CLK_50(clk), .RST(rst_b), .pix_en(b_pen), .CounterX(b_x), .CounterY(b_y),
    .InDisplayArea(b_disp), .h_sync(b_hs), .v_sync(b_vs),
    .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(b_fc)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_c (
    .CLK_50(clk), .RST(rst_c), .pix_en(c_pen), .CounterX(c_x), .CounterY(c_y),
    .InDisplayArea(c_disp), .h_sync(c_hs), .v_sync(c_vs),
    .line_start(c_ls), .frame_start(c_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(c_fc)
`endif
  );

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    repeat (5) tick1();
    checks++;
    if ({a_pen, a_disp, a_ls, a_fs, a_hs, a_vs} !== 6'b000011) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000011", {a_pen, a_disp, a_ls, a_fs, a_hs, a_vs});
    end
    checks++;
    if (a_x !== 10'd0 || a_y !== 10'd0) begin
      failures++;
      $display("FAIL reset_pos got=(%0d,%0d) exp=(0,0)", a_x, a_y);
    end
    rst_a = 1'b0;
    tick1();
    checks++;
    if ({a_pen, a_disp, a_ls, a_fs, a_hs, a_vs} !== 6'b111111) begin
      failures++;
      $display("FAIL first_pix_flags got=%b exp=111111", {a_pen, a_disp, a_ls, a_fs, a_hs, a_vs});
    end
    checks++;
    if (a_x !== 10'd0 || a_y !== 10'd0) begin
      failures++;
      $display("FAIL first_pix_pos got=(%0d,%0d) exp=(0,0)", a_x, a_y);
    end
    tick1();
    checks++;
    if ({a_pen, a_ls, a_fs, a_disp} !== 4'b0001 || a_x !== 10'd0) begin
      failures++;
      $display("FAIL gap_after_first got=pen%b ls%b fs%b disp%b x=%0d exp=pen0 ls0 fs0 disp1 x=0",
               a_pen, a_ls, a_fs, a_disp, a_x);
    end
    tick1();
    checks++;
    if (a_pen !== 1'b1 || a_x !== 10'd1 || a_ls !== 1'b0) begin
      failures++;
      $display("FAIL second_pix got=pen%b x=%0d ls%b exp=pen1 x=1 ls0", a_pen, a_x, a_ls);
    end
  endtask

  task automatic test_pixel_rate();
    logic       prev_pen, prev_hs, prev_disp;
    logic [9:0] prev_x, prev_y, exp_x;
    prev_pen = a_pen; prev_x = a_x; prev_y = a_y; prev_hs = a_hs; prev_disp = a_disp;
    for (int i = 0; i < 2000; i++) begin
      tick1();
      checks++;
      if (a_pen !== ~prev_pen) begin
        failures++;
        $display("FAIL pix_en_period cyc=%0d got=%b exp=%b", i, a_pen, ~prev_pen);
      end
      if (a_pen) begin
        exp_x = (prev_x == 10'd799) ? 10'd0 : prev_x + 10'd1;
        checks++;
        if (a_x !== exp_x) begin
          failures++;
          $display("FAIL x_advance cyc=%0d got=%0d exp=%0d", i, a_x, exp_x);
        end
      end else begin
        checks++;
        if ({a_x, a_y, a_hs, a_disp} !== {prev_x, prev_y, prev_hs, prev_disp}) begin
          failures++;
          $display("FAIL hold_between_pulses cyc=%0d got x=%0d y=%0d exp x=%0d y=%0d",
                   i, a_x, a_y, prev_x, prev_y);
        end
      end
      prev_pen = a_pen; prev_x = a_x; prev_y = a_y; prev_hs = a_hs; prev_disp = a_disp;
    end
  endtask

  task automatic test_line_timing();
    int   exp_x, exp_y, ls_cnt;
    logic e_disp, e_hs;
    rst_a = 1'b1;
    tick1(); tick1();
    rst_a = 1'b0;
    exp_x = 0; exp_y = 0; ls_cnt = 0;
    for (int i = 0; i < 1700; i++) begin
      tick1();
      if (a_pen) begin
        e_disp = (exp_x < 640) && (exp_y < 480);
        e_hs   = !((exp_x >= 656) && (exp_x < 752));
        checks++;
        if (a_x !== exp_x[9:0] || a_y !== exp_y[9:0]) begin
          failures++;
          $display("FAIL line_pos got=(%0d,%0d) exp=(%0d,%0d)", a_x, a_y, exp_x, exp_y);
        end
        checks++;
        if (a_disp !== e_disp || a_hs !== e_hs || a_vs !== 1'b1) begin
          failures++;
          $display("FAIL line_decode x=%0d got disp%b hs%b vs%b exp disp%b hs%b vs1",
                   exp_x, a_disp, a_hs, a_vs, e_disp, e_hs);
        end
        checks++;
        if (a_ls !== (exp_x == 0)) begin
          failures++;
          $display("FAIL line_start x=%0d got=%b exp=%b", exp_x, a_ls, (exp_x == 0));
        end
        if (a_ls) ls_cnt++;
        if (exp_x == 799) begin exp_x = 0; exp_y = exp_y + 1; end
        else exp_x = exp_x + 1;
      end else begin
        checks++;
        if ({a_ls, a_fs} !== 2'b00) begin
          failures++;
          $display("FAIL strobe_width cyc=%0d got ls%b fs%b exp 00", i, a_ls, a_fs);
        end
      end
    end
    checks++;
    if (ls_cnt != 2) begin
      failures++;
      $display("FAIL line_start_count got=%0d exp=2", ls_cnt);
    end
  endtask

  task automatic test_frame_timing();
    int   exp_x, exp_y, fs_cnt, last_fs;
    logic e_disp, e_hs, e_vs;
    rst_b = 1'b1;
    tick1(); tick1();
    rst_b = 1'b0;
    exp_x = 0; exp_y = 0; fs_cnt = 0; last_fs = -1;
    for (int i = 1; i <= 600; i++) begin
      tick1();
      if (b_pen) begin
        e_disp = (exp_x < 8) && (exp_y < 4);
        e_hs   = !((exp_x >= 10) && (exp_x < 13));
        e_vs   = !((exp_y >= 5) && (exp_y < 7));
        checks++;
        if (b_x !== exp_x[9:0] || b_y !== exp_y[9:0]) begin
          failures++;
          $display("FAIL frame_pos got=(%0d,%0d) exp=(%0d,%0d)", b_x, b_y, exp_x, exp_y);
        end
        checks++;
        if ({b_disp, b_hs, b_vs} !== {e_disp, e_hs, e_vs}) begin
          failures++;
          $display("FAIL frame_decode (%0d,%0d) got disp%b hs%b vs%b exp disp%b hs%b vs%b",
                   exp_x, exp_y, b_disp, b_hs, b_vs, e_disp, e_hs, e_vs);
        end
        checks++;
        if (b_fs !== (exp_x == 0 && exp_y == 0) || b_ls !== (exp_x == 0)) begin
          failures++;
          $display("FAIL frame_strobes (%0d,%0d) got fs%b ls%b", exp_x, exp_y, b_fs, b_ls);
        end
        if (b_fs) begin
          fs_cnt++;
          if (last_fs >= 0) begin
            checks++;
            if (i - last_fs != 256) begin
              failures++;
              $display("FAIL frame_period got=%0d exp=256", i - last_fs);
            end
          end
          last_fs = i;
        end
        if (exp_x == 15) begin exp_x = 0; exp_y = (exp_y == 7) ? 0 : exp_y + 1; end
        else exp_x = exp_x + 1;
      end
    end
    checks++;
    if (fs_cnt != 3) begin
      failures++;
      $display("FAIL frame_start_count got=%0d exp=3", fs_cnt);
    end
  endtask

  task automatic test_mid_frame_reset();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick1();
      if (b_pen && b_x == 10'd11 && b_y == 10'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midreset_reach got=timeout exp=(11,5)");
    end
    checks++;
    if ({b_hs, b_vs} !== 2'b00) begin
      failures++;
      $display("FAIL midreset_syncs_before got=%b exp=00", {b_hs, b_vs});
    end
    rst_b = 1'b1;
    tick1();
    rst_b = 1'b0;
    checks++;
    if ({b_pen, b_disp, b_ls, b_fs, b_hs, b_vs} !== 6'b000011 || b_x !== 10'd0 || b_y !== 10'd0) begin
      failures++;
      $display("FAIL midreset_values got=%b (%0d,%0d) exp=000011 (0,0)",
               {b_pen, b_disp, b_ls, b_fs, b_hs, b_vs}, b_x, b_y);
    end
`ifdef VGA_FRAME_COUNT_EN
    checks++;
    if (b_fc !== 8'd0) begin
      failures++;
      $display("FAIL midreset_frame_count got=%0d exp=0", b_fc);
    end
`endif
    tick1();
    checks++;
    if ({b_pen, b_disp, b_ls, b_fs, b_hs, b_vs} !== 6'b111111 || b_x !== 10'd0 || b_y !== 10'd0) begin
      failures++;
      $display("FAIL midreset_restart got=%b (%0d,%0d) exp=111111 (0,0)",
               {b_pen, b_disp, b_ls, b_fs, b_hs, b_vs}, b_x, b_y);
    end
  endtask

  task automatic test_clk_div1_polarity();
    int   px, py;
    logic e_hs;
    rst_c = 1'b1;
    tick1(); tick1();
    checks++;
    if ({c_pen, c_hs, c_vs} !== 3'b000) begin
      failures++;
      $display("FAIL div1_reset got=pen%b hs%b vs%b exp 000", c_pen, c_hs, c_vs);
    end
    rst_c = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick1();
      px = i % 16;
      py = i / 16;
      e_hs = (px >= 10) && (px < 13);
      checks++;
      if (c_pen !== 1'b1 || c_x !== px[9:0] || c_y !== py[9:0]) begin
        failures++;
        $display("FAIL div1_scan i=%0d got pen%b (%0d,%0d) exp pen1 (%0d,%0d)",
                 i, c_pen, c_x, c_y, px, py);
      end
      checks++;
      if (c_hs !== e_hs || c_vs !== 1'b0) begin
        failures++;
        $display("FAIL div1_sync_pol x=%0d got hs%b vs%b exp hs%b vs0", px, c_hs, c_vs, e_hs);
      end
    end
  endtask

`ifdef VGA_FRAME_COUNT_EN
  task automatic test_frame_count();
    int fs_seen;
    logic [7:0] exp_fc;
    rst_b = 1'b1;
    tick1(); tick1();
    checks++;
    if (b_fc !== 8'd0) begin
      failures++;
      $display("FAIL fc_reset got=%0d exp=0", b_fc);
    end
    rst_b = 1'b0;
    fs_seen = 0;
    for (int i = 0; i < 70000 && fs_seen < 257; i++) begin
      tick1();
      if (b_fs) begin
        fs_seen++;
        exp_fc = 8'((fs_seen - 1) % 256);
        checks++;
        if (b_fc !== exp_fc) begin
          failures++;
          $display("FAIL fc_step fs#%0d got=%0d exp=%0d", fs_seen, b_fc, exp_fc);
        end
      end
    end
    checks++;
    if (fs_seen != 257) begin
      failures++;
      $display("FAIL fc_frames got=%0d exp=257", fs_seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pixel_rate();
    test_line_timing();
    test_frame_timing();
    test_mid_frame_reset();
    test_clk_div1_polarity();
`ifdef VGA_FRAME_COUNT_EN
    test_frame_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream raster timing stage for the 640x480@60 VGA path on the 50 MHz board clock.
- Derives a pixel-rate enable from CLK_50 and runs horizontal and vertical position counters.
- Drives h_sync, v_sync, CounterX, CounterY and InDisplayArea straight into the pixel/colour generator.
- Also provides line_start and frame_start strobes, so downstream renderers and animation logic need no private clock dividers.

Parameters:
- CLK_DIV, 2: CLK_50 cycles per pixel; 2 gives a 25 MHz pixel rate; legal range 1..16.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_SYNC_POL, 0: asserted level of h_sync (0 = active-low).
- V_SYNC_POL, 0: asserted level of v_sync (0 = active-low).

Ports:
- CLK_50  in  1  system clock, 50 MHz.
- RST  in  1  synchronous reset, active-high.
- pix_en  out  1  one-CLK_50-cycle pulse, once every CLK_DIV cycles.
- CounterX  out  10  current pixel column, 0..H_TOTAL-1.
- CounterY  out  10  current line, 0..V_TOTAL-1.
- InDisplayArea  out  1  high when CounterX < H_ACTIVE and CounterY < V_ACTIVE.
- h_sync  out  1  horizontal sync.
- v_sync  out  1  vertical sync.
- line_start  out  1  pulse when CounterX becomes 0.
- frame_start  out  1  pulse when the position becomes (0,0).
- frame_count  out  8  frame counter; present only with VGA_FRAME_COUNT_EN.

Behaviour:
- Derived sizes: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be <= 1024; the implementation carries a synthesis-time check.
- All outputs are registered. No combinational path from RST to any output.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = 1 on the cycle where div_cnt == CLK_DIV-1. With CLK_DIV = 1, pix_en is constantly 1 outside reset.
- Reset values (while RST = 1 and on the cycle after release):
  - div_cnt = 0, pix_en = 0
  - CounterX = 0, CounterY = 0
  - InDisplayArea = 0, line_start = 0, frame_start = 0
  - h_sync = ~H_SYNC_POL, v_sync = ~V_SYNC_POL (both deasserted)
  - started = 0, frame_count = 0
- State machine with two states, IDLE (started = 0) and RUN (started = 1):
  - IDLE: on the first pix_en after reset, go to RUN. Position stays (0,0) and is not advanced. Outputs load the decode for (0,0): InDisplayArea = 1, line_start = 1, frame_start = 1.
  - RUN, on each pix_en:
    - If CounterX < H_TOTAL-1, CounterX increments.
    - Otherwise CounterX = 0, and CounterY increments, or wraps to 0 when it equals V_TOTAL-1.
- Output decode is computed from the next position, so every output on a given cycle is consistent with that cycle's CounterX/CounterY. There is no skew between sync, counters and display area.
- Horizontal sync: h_sync = H_SYNC_POL when H_ACTIVE+H_FP <= CounterX < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~H_SYNC_POL.
- Vertical sync: v_sync = V_SYNC_POL when V_ACTIVE+V_FP <= CounterY < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise ~V_SYNC_POL. v_sync changes only together with the CounterX wrap.
- Strobes: line_start and frame_start are high only on the pix_en cycle that loads CounterX = 0 or position (0,0) respectively. They are 0 on all other cycles; width is exactly one CLK_50 cycle.
- Outputs hold their values between pix_en pulses.
- RST asserted mid-frame: on the next edge every register returns to its reset value, and the raster restarts from IDLE after release. No partial line or sync pulse is carried over.

Optional Feature:
- Macro VGA_FRAME_COUNT_EN.
- Defined: adds the 8-bit frame_count output, reset to 0. It increments on every frame_start except the first one after reset, and wraps 255 -> 0. It provides a frame-rate timebase for animation, replacing ad-hoc dividers.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RST for 5 cycles, then release. Required: all outputs at reset values; first pix_en 2 cycles after release; that cycle shows CounterX = 0, CounterY = 0, InDisplayArea = 1, line_start = 1, frame_start = 1.
- Pixel rate: run 2000 cycles with CLK_DIV = 2. Required: pix_en period is exactly 2 cycles; CounterX advances by 1 per pix_en; outputs are stable between pulses.
- Line timing: InDisplayArea falls when CounterX goes 639 -> 640. h_sync goes low at CounterX = 656 and high at 752. At 799 -> 0, CounterY increments and line_start pulses once.
- Frame timing: v_sync is low for CounterY 490..491 only. At (799,524) -> (0,0), frame_start pulses. Each frame is exactly 800*525*2 = 840000 CLK_50 cycles.
- Mid-frame reset: assert RST at CounterX = 700, CounterY = 300 for 1 cycle. Required: next cycle shows the reset values and no sync asserted; the restart sequence is identical to the reset scenario.
- VGA_FRAME_COUNT_EN: run 257 frames. Required: frame_count steps 0 -> 1 at the second frame_start and reads 0 again after the 256th increment (wrap).
